// File: rtl/spi_3w_responder.sv
// 3-wire SPI responder: decodes R/W + address + data frames on sdio and bridges
// them onto a local register bus with 1-clk read latency, returning read data on sdio.
module spi_3w_responder #(
   parameter int A_WIDTH = 16,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sclk,
   input  logic               cs,
   inout  wire                sdio,
   output logic [A_WIDTH-1:0] reg_addr,
   output logic [D_WIDTH-1:0] reg_wdata,
   output logic               reg_wr_en,
   output logic               reg_rd_en,
   input  logic [D_WIDTH-1:0] reg_rdata,
   output logic               busy,
   output logic               frame_err
);

   localparam int W  = (A_WIDTH > D_WIDTH) ? A_WIDTH : D_WIDTH;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] A_LAST = CW'(A_WIDTH - 1);
   localparam logic [CW-1:0] D_LAST = CW'(D_WIDTH - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CMD     = 3'd1;
   localparam logic [2:0] S_ADDR    = 3'd2;
   localparam logic [2:0] S_WR_DATA = 3'd3;
   localparam logic [2:0] S_RD_LOAD = 3'd4;
   localparam logic [2:0] S_RD_DATA = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic [2:0]         sclk_sync_q, sclk_sync_d;
   logic [1:0]         cs_sync_q, cs_sync_d;
   logic [1:0]         sdio_sync_q, sdio_sync_d;
   logic [2:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               rw_q, rw_d;
   logic [W-2:0]       rx_q, rx_d;
   logic [D_WIDTH-1:0] tx_q, tx_d;
   logic               sdio_oe_q, sdio_oe_d;
   logic               sdio_out_q, sdio_out_d;
   logic [A_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic [D_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
   logic               reg_wr_en_q, reg_wr_en_d;
   logic               reg_rd_en_q, reg_rd_en_d;
   logic               busy_q, busy_d;
   logic               frame_err_q, frame_err_d;
   logic               sclk_rise, sclk_fall, cs_hi, sdio_in;

   assign sdio      = sdio_oe_q ? sdio_out_q : 1'bz;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_wr_en = reg_wr_en_q;
   assign reg_rd_en = reg_rd_en_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_hi     = cs_sync_q[1];
   assign sdio_in   = sdio_sync_q[1];

   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], sclk};
      cs_sync_d   = {cs_sync_q[0], cs};
      sdio_sync_d = {sdio_sync_q[0], sdio};
      state_d     = state_q;
      cnt_d       = cnt_q;
      rw_d        = rw_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      sdio_oe_d   = sdio_oe_q;
      sdio_out_d  = sdio_out_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_en_d = 1'b0;
      reg_rd_en_d = 1'b0;
      frame_err_d = 1'b0;

      // cs deassertion overrides everything; a completed frame (DONE) is not an error
      if (cs_hi && state_q != S_IDLE) begin
         state_d     = S_IDLE;
         sdio_oe_d   = 1'b0;
         frame_err_d = (state_q != S_DONE);
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (!cs_hi) state_d = S_CMD;
            end
            S_CMD: if (sclk_rise) begin
               rw_d    = sdio_in;
               cnt_d   = '0;
               state_d = S_ADDR;
            end
            S_ADDR: if (sclk_rise) begin
               rx_d  = {rx_q[W-3:0], sdio_in};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == A_LAST) begin
                  reg_addr_d = {rx_q[A_WIDTH-2:0], sdio_in};
                  cnt_d      = '0;
                  if (rw_q) begin
                     reg_rd_en_d = 1'b1;
                     state_d     = S_RD_LOAD;
                  end else begin
                     state_d = S_WR_DATA;
                  end
               end
            end
            S_WR_DATA: if (sclk_rise) begin
               rx_d  = {rx_q[W-3:0], sdio_in};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == D_LAST) begin
                  reg_wdata_d = {rx_q[D_WIDTH-2:0], sdio_in};
                  reg_wr_en_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = S_DONE;
               end
            end
            // The strobe cycle is skipped; reg_rdata is valid the clk after it.
            S_RD_LOAD: if (!reg_rd_en_q) begin
               tx_d    = reg_rdata;
               state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
               if (sclk_fall) begin
                  sdio_oe_d  = 1'b1;
                  sdio_out_d = tx_q[D_WIDTH-1];
                  tx_d       = {tx_q[D_WIDTH-2:0], 1'b0};
               end
               if (sclk_rise) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == D_LAST) begin
                     sdio_oe_d = 1'b0;
                     cnt_d     = '0;
                     state_d   = S_DONE;
                  end
               end
            end
            S_DONE:  sdio_oe_d = 1'b0;
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         // cs synchronizer starts at the idle (deselected) level
         cs_sync_q   <= 2'b11;
         sdio_sync_q <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rw_q        <= 1'b0;
         rx_q        <= '0;
         tx_q        <= '0;
         sdio_oe_q   <= 1'b0;
         sdio_out_q  <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_wr_en_q <= 1'b0;
         reg_rd_en_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         sdio_sync_q <= sdio_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rw_q        <= rw_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         sdio_oe_q   <= sdio_oe_d;
         sdio_out_q  <= sdio_out_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_en_q <= reg_wr_en_d;
         reg_rd_en_q <= reg_rd_en_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_spi_3w_responder.sv
// Bench for spi_3w_responder: bit-banged 3-wire master, echo register file with
// 1-clk read latency, and a byte-array reference model of the register contents.
`timescale 1ns/1ps
module tb_spi_3w_responder;

   localparam int H = 6;  // clk cycles per sclk phase

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        cs = 1'b1;
   logic        m_oe = 1'b0;
   logic        m_out = 1'b0;
   wire         sdio;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_wr_en;
   logic        reg_rd_en;
   logic [7:0]  reg_rdata = 8'h00;
   logic        busy;
   logic        frame_err;

   int tests = 0;
   int fails = 0;

   assign sdio = m_oe ? m_out : 1'bz;

   always #5 clk = ~clk;

   spi_3w_responder #(.A_WIDTH(16), .D_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .sdio(sdio),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
      .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
   );

   // Register file environment: unwritten locations read as addr ^ 0xC3; rdata is
   // garbage except on the clk after a read strobe.
   logic [7:0] env_mem [0:255];
   logic       env_vld [0:255];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) env_vld[i] <= 1'b0;
      end else if (reg_wr_en) begin
         env_mem[reg_addr[7:0]] <= reg_wdata;
         env_vld[reg_addr[7:0]] <= 1'b1;
      end
      if (reg_rd_en)
         reg_rdata <= env_vld[reg_addr[7:0]] ? env_mem[reg_addr[7:0]] : (reg_addr[7:0] ^ 8'hC3);
      else
         reg_rdata <= 8'($urandom);
   end

   // Observation counters, sampled away from the active edge
   int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0, oe_cycles = 0;
   logic [15:0] last_waddr = '0, last_raddr = '0;
   logic [7:0]  last_wdata = '0;
   always @(negedge clk) begin
      if (reg_wr_en) begin
         wr_cnt     <= wr_cnt + 1;
         last_waddr <= reg_addr;
         last_wdata <= reg_wdata;
      end
      if (reg_rd_en) begin
         rd_cnt     <= rd_cnt + 1;
         last_raddr <= reg_addr;
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (reg_wr_en && reg_rd_en) both_cnt <= both_cnt + 1;
      if (dut.sdio_oe_q) oe_cycles <= oe_cycles + 1;
   end

   // Reference model of the register file (first rst clears written flags)
   logic [7:0] ref_mem [0:255];

   logic        busy_mid, oe_end, snap_pre_oe, snap_oe, snap_busy, snap_wr, snap_rd;
   logic [15:0] snap_addr;
   logic [7:0]  snap_wdata;

   task automatic spi_xfer(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                           input int nbits, input int extra, input int rst_at,
                           output logic [7:0] rd);
      logic [24:0] frame;
      frame = {rw, addr, wd};
      rd = '0;
      @(negedge clk);
      cs = 1'b0;
      repeat (H) @(negedge clk);
      busy_mid = busy;
      for (int i = 0; i < nbits + extra; i++) begin
         if (i == rst_at) begin
            repeat (4) @(negedge clk);
            snap_pre_oe = dut.sdio_oe_q;
            rst = 1'b1;
            @(negedge clk);
            snap_oe    = dut.sdio_oe_q;
            snap_busy  = busy;
            snap_wr    = reg_wr_en;
            snap_rd    = reg_rd_en;
            snap_addr  = reg_addr;
            snap_wdata = reg_wdata;
            rst = 1'b0;
            break;
         end
         if (i < 17 || (!rw && i < 25)) begin
            m_oe  = 1'b1;
            m_out = frame[5'(24 - i)];
         end else begin
            m_oe = 1'b0;
         end
         repeat (H) @(negedge clk);
         if (rw && i >= 17 && i < 25) rd = {rd[6:0], sdio};
         sclk = 1'b1;
         repeat (H) @(negedge clk);
         sclk = 1'b0;
      end
      m_oe = 1'b0;
      repeat (H) @(negedge clk);
      oe_end = dut.sdio_oe_q;
      cs = 1'b1;
      repeat (2 * H) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (reg_addr !== 16'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", reg_addr); end
      tests++; if (reg_wdata !== 8'h0) begin fails++; $display("FAIL reset_wdata got=%h exp=0", reg_wdata); end
      tests++; if (reg_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got=%b exp=0", reg_wr_en); end
      tests++; if (reg_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got=%b exp=0", reg_rd_en); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      tests++; if (dut.sdio_oe_q !== 1'b0) begin fails++; $display("FAIL reset_sdio_oe got=%b exp=0", dut.sdio_oe_q); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", busy); end
      $display("[TB] reset: checked");
   endtask

   task automatic test_write(input logic [15:0] addr, input logic [7:0] wd, input int extra);
      int w0, r0, e0, o0;
      logic [7:0] dummy;
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cycles;
      spi_xfer(1'b0, addr, wd, 25, extra, -1, dummy);
      ref_mem[addr[7:0]] = wd;
      tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL wr_strobes got=%0d exp=1", wr_cnt - w0); end
      tests++; if (rd_cnt - r0 !== 0) begin fails++; $display("FAIL wr_rd_strobes got=%0d exp=0", rd_cnt - r0); end
      tests++; if (last_waddr !== addr) begin fails++; $display("FAIL wr_addr got=%h exp=%h", last_waddr, addr); end
      tests++; if (last_wdata !== wd) begin fails++; $display("FAIL wr_data got=%h exp=%h", last_wdata, wd); end
      tests++; if (reg_addr !== addr) begin fails++; $display("FAIL wr_addr_held got=%h exp=%h", reg_addr, addr); end
      tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL wr_frame_err got=%0d exp=0", err_cnt - e0); end
      tests++; if (oe_cycles - o0 !== 0) begin fails++; $display("FAIL wr_sdio_drive got=%0d exp=0", oe_cycles - o0); end
      tests++; if (busy_mid !== 1'b1) begin fails++; $display("FAIL wr_busy_mid got=%b exp=1", busy_mid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy_end got=%b exp=0", busy); end
      $display("[TB] write addr=%h data=%h extra=%0d strobes=%0d", addr, wd, extra, wr_cnt - w0);
   endtask

   task automatic test_read(input logic [15:0] addr);
      int w0, r0, e0, o0;
      logic [7:0] rd, exp_d;
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cycles;
      exp_d = ref_mem[addr[7:0]];
      spi_xfer(1'b1, addr, 8'h00, 25, 0, -1, rd);
      tests++; if (rd_cnt - r0 !== 1) begin fails++; $display("FAIL rd_strobes got=%0d exp=1", rd_cnt - r0); end
      tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL rd_wr_strobes got=%0d exp=0", wr_cnt - w0); end
      tests++; if (last_raddr !== addr) begin fails++; $display("FAIL rd_addr got=%h exp=%h", last_raddr, addr); end
      tests++; if (rd !== exp_d) begin fails++; $display("FAIL rd_data got=%h exp=%h", rd, exp_d); end
      tests++; if (oe_end !== 1'b0) begin fails++; $display("FAIL rd_oe_after_last got=%b exp=0", oe_end); end
      tests++; if (oe_cycles - o0 <= 0) begin fails++; $display("FAIL rd_sdio_drive got=%0d exp=>0", oe_cycles - o0); end
      tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL rd_frame_err got=%0d exp=0", err_cnt - e0); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy_end got=%b exp=0", busy); end
      $display("[TB] read addr=%h data=%h exp=%h", addr, rd, exp_d);
   endtask

   task automatic test_abort();
      int w0, r0, e0;
      logic [7:0] dummy;
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      spi_xfer(1'b0, 16'hBEEF, 8'h77, 10, 0, -1, dummy);
      tests++; if (wr_cnt - w0 + rd_cnt - r0 !== 0) begin fails++; $display("FAIL abort_strobes got=%0d exp=0", wr_cnt - w0 + rd_cnt - r0); end
      tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL abort_frame_err_clks got=%0d exp=1", err_cnt - e0); end
      tests++; if (dut.sdio_oe_q !== 1'b0) begin fails++; $display("FAIL abort_sdio_oe got=%b exp=0", dut.sdio_oe_q); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
      $display("[TB] abort after 9 addr bits: frame_err clks=%0d", err_cnt - e0);
   endtask

   task automatic test_rst_mid_read();
      logic [7:0] dummy;
      logic [15:0] addr;
      addr = 16'($urandom) | 16'h0100;
      spi_xfer(1'b1, addr, 8'h00, 25, 0, 19, dummy);
      tests++; if (snap_pre_oe !== 1'b1) begin fails++; $display("FAIL rst_pre_oe got=%b exp=1", snap_pre_oe); end
      tests++; if (snap_oe !== 1'b0) begin fails++; $display("FAIL rst_sdio_oe got=%b exp=0", snap_oe); end
      tests++; if (snap_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", snap_busy); end
      tests++; if ({snap_wr, snap_rd} !== 2'b00) begin fails++; $display("FAIL rst_strobes got=%b exp=00", {snap_wr, snap_rd}); end
      tests++; if (snap_addr !== 16'h0) begin fails++; $display("FAIL rst_addr got=%h exp=0", snap_addr); end
      tests++; if (snap_wdata !== 8'h0) begin fails++; $display("FAIL rst_wdata got=%h exp=0", snap_wdata); end
      $display("[TB] rst during read addr=%h: oe=%b busy=%b", addr, snap_oe, snap_busy);
      test_read(16'h0042);
   endtask

   task automatic test_back_to_back();
      logic [15:0] addr;
      test_write(16'h0001, 8'h11, 0);
      test_read(16'h0001);
      for (int k = 0; k < 8; k++) begin
         addr = {8'($urandom), 8'($urandom_range(0, 3))};
         if ($urandom_range(0, 1) == 1) test_read(addr);
         else test_write(addr, 8'($urandom), 0);
      end
      tests++; if (both_cnt !== 0) begin fails++; $display("FAIL same_clk_strobes got=%0d exp=0", both_cnt); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hC3;
      test_reset();
      test_write(16'h1234, 8'hA5, 0);
      test_read(16'h00FF);
      test_abort();
      test_write(16'h0F0F, 8'h5A, 4);
      test_rst_mid_read();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
